// File: rtl/hazard3_irq_input_cond_pkg.sv
// Shared constants and helpers for the IRQ input conditioning block.
//   HZ3_NUM_IRQS / HZ3_SYNC_STAGES / HZ3_FILTER_CYCLES : default sizing
//   irq_mode_e                                     : per-line latch mode
//   filt_cnt_w()                                   : glitch-filter counter width
package hazard3_irq_input_cond_pkg;

  localparam int HZ3_NUM_IRQS      = 32;
  localparam int HZ3_SYNC_STAGES   = 2;
  localparam int HZ3_FILTER_CYCLES = 3;

  typedef enum logic {
    IRQ_MODE_LEVEL = 1'b0,
    IRQ_MODE_EDGE  = 1'b1
  } irq_mode_e;

  // Counter only has to reach FILTER_CYCLES-1; never narrower than one bit.
  function automatic int filt_cnt_w(input int filter_cycles);
    return (filter_cycles > 1) ? $clog2(filter_cycles) : 1;
  endfunction

endpackage

// File: rtl/hazard3_irq_cond_1bit.sv
// One IRQ line: optional inversion, synchroniser chain, glitch filter and
// level / rising-edge-sticky output.
//   clk, rst  : core clock, synchronous active-high reset
//   irq_i     : raw asynchronous IRQ line
//   clr_i     : one-cycle clear strobe for the edge-mode pending bit
//   irq_o     : conditioned IRQ (registered)
//   status_o  : filtered level (registered)
module hazard3_irq_cond_1bit
  import hazard3_irq_input_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = HZ3_SYNC_STAGES,
  parameter int FILTER_CYCLES = HZ3_FILTER_CYCLES,
  parameter bit EDGE          = 1'b0,
  parameter bit INVERT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic clr_i,
  output logic irq_o,
  output logic status_o
);

  localparam irq_mode_e MODE  = EDGE ? IRQ_MODE_EDGE : IRQ_MODE_LEVEL;
  localparam int        W_CNT = filt_cnt_w(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   y;
  logic                   filt;

  // Inversion happens at the first flop so an active-low line that is already
  // asserted when reset releases is treated as a genuine assertion.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= irq_i ^ INVERT;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign y = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign filt = y;
    end else begin : g_filt
      localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(FILTER_CYCLES - 1);

      logic [W_CNT-1:0] cnt_q, cnt_d;
      logic             filt_q, filt_d;

      // Any cycle where y agrees with the accepted level restarts the count,
      // so only an unbroken run of FILTER_CYCLES differing samples is accepted.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (y != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = y;
          end else begin
            cnt_d = cnt_q + W_CNT'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  logic prev_q;
  logic pend_q, pend_d;

  // Set wins over clear when a rise and a strobe land on the same edge.
  always_comb begin
    pend_d = (filt & ~prev_q) | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= filt;
      pend_q <= pend_d;
    end
  end

  // Level-mode lines leave prev/pend dangling; they are trimmed away.
  assign irq_o    = (MODE == IRQ_MODE_EDGE) ? pend_q : filt;
  assign status_o = filt;

endmodule

// File: rtl/hazard3_irq_input_cond.sv
// Conditions raw external IRQ lines before the interrupt controller's irq[]
// inputs. irq_out is fully registered, so the controller may bypass its own
// input registers.
//   clk, rst    : core clock, synchronous active-high reset
//   irq_in      : raw asynchronous IRQ lines
//   irq_clr     : clear strobes for edge-mode pending bits
//   irq_out     : conditioned IRQs to controller irq[]
//   irq_status  : filtered levels for debug/readback
//   wakeup      : OR of irq_out (registers only, no path from irq_in)
module hazard3_irq_input_cond
  import hazard3_irq_input_cond_pkg::*;
#(
  parameter int                  NUM_IRQS      = HZ3_NUM_IRQS,
  parameter int                  SYNC_STAGES   = HZ3_SYNC_STAGES,
  parameter int                  FILTER_CYCLES = HZ3_FILTER_CYCLES,
  parameter logic [NUM_IRQS-1:0] IRQ_EDGE_MASK = '0,
  parameter logic [NUM_IRQS-1:0] IRQ_INVERT    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQS-1:0] irq_in,
  input  logic [NUM_IRQS-1:0] irq_clr,
  output logic [NUM_IRQS-1:0] irq_out,
  output logic [NUM_IRQS-1:0] irq_status,
  output logic                wakeup
);

  for (genvar g = 0; g < NUM_IRQS; g++) begin : g_irq
    hazard3_irq_cond_1bit #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .EDGE          (IRQ_EDGE_MASK[g]),
      .INVERT        (IRQ_INVERT[g])
    ) u_cond (
      .clk      (clk),
      .rst      (rst),
      .irq_i    (irq_in[g]),
      .clr_i    (irq_clr[g]),
      .irq_o    (irq_out[g]),
      .status_o (irq_status[g])
    );
  end

  assign wakeup = |irq_out;

endmodule

// File: tb/tb_hazard3_irq_input_cond.sv
`timescale 1ns/1ps
module tb_hazard3_irq_input_cond;

  localparam int N = 4;
  localparam int S = 2;
  localparam int F = 3;
  // IRQ0 level, IRQ1 edge, IRQ2 level active-low, IRQ3 edge active-low
  localparam logic [N-1:0] EMASK = 4'b1010;
  localparam logic [N-1:0] INV   = 4'b1100;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic [N-1:0] irq_in  = INV;
  logic [N-1:0] irq_clr = '0;
  logic [N-1:0] irq_out;
  logic [N-1:0] irq_status;
  logic         wakeup;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard3_irq_input_cond #(
    .NUM_IRQS      (N),
    .SYNC_STAGES   (S),
    .FILTER_CYCLES (F),
    .IRQ_EDGE_MASK (EMASK),
    .IRQ_INVERT    (INV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .irq_clr    (irq_clr),
    .irq_out    (irq_out),
    .irq_status (irq_status),
    .wakeup     (wakeup)
  );

  // Reference model: histories of true-polarity input samples and of the
  // synchronised value seen at each edge since reset. A line's filtered level
  // flips when the last F synchronised samples all disagree with it; an edge
  // line latches one edge after its filtered level rises.
  logic [N-1:0] xh[$];
  logic [N-1:0] yh[$];
  logic [N-1:0] m_filt = '0;
  logic [N-1:0] m_rose = '0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_fnew;
  logic [N-1:0] m_yk;
  bit           m_all;

  function automatic logic [N-1:0] y_seen();
    return (xh.size() >= S) ? xh[xh.size()-S] : '0;
  endfunction

  function automatic logic [N-1:0] exp_out();
    return (EMASK & m_pend) | (~EMASK & m_filt);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      xh.delete();
      yh.delete();
      m_filt = '0;
      m_rose = '0;
      m_pend = '0;
    end else begin
      yh.push_back(y_seen());
      xh.push_back(irq_in ^ INV);
      m_fnew = m_filt;
      for (int i = 0; i < N; i++) begin
        if (yh.size() >= F) begin
          m_all = 1'b1;
          for (int k = 1; k <= F; k++) begin
            m_yk = yh[yh.size()-k];
            if (m_yk[i] == m_filt[i]) m_all = 1'b0;
          end
          if (m_all) m_fnew[i] = ~m_filt[i];
        end
      end
      m_pend = m_rose | (m_pend & ~irq_clr);
      m_rose = m_fnew & ~m_filt;
      m_filt = m_fnew;
      while (xh.size() > 8) void'(xh.pop_front());
      while (yh.size() > 8) void'(yh.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = INV; irq_clr = '0;
    cyc(3);
    checks++;
    if (irq_out !== '0 || irq_status !== '0 || wakeup !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%b status=%b wakeup=%b, required all 0", irq_out, irq_status, wakeup);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (irq_out !== '0 || wakeup !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d: out=%b wakeup=%b, required 0", k, irq_out, wakeup);
      end
    end
  endtask

  task automatic test_level();
    irq_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (irq_out[0] !== (k >= 5) || wakeup !== (k >= 5)) begin
        errors++;
        $display("FAIL level_rise k=%0d: out0=%b wakeup=%b, required %0d", k, irq_out[0], wakeup, k >= 5);
      end
    end
    irq_in[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (irq_out[0] !== (k < 5) || wakeup !== (k < 5)) begin
        errors++;
        $display("FAIL level_fall k=%0d: out0=%b wakeup=%b, required %0d", k, irq_out[0], wakeup, k < 5);
      end
    end
  endtask

  task automatic test_glitch();
    irq_in[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      checks++;
      if (irq_out[0] !== 1'b0 || irq_status[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_2cyc k=%0d: out0=%b status0=%b, required 0", k, irq_out[0], irq_status[0]);
      end
      if (k == 2) irq_in[0] = 1'b0;
    end
    irq_in[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      checks++;
      if (irq_out[0] !== (k >= 5 && k <= 7) || irq_status[0] !== (k >= 5 && k <= 7)) begin
        errors++;
        $display("FAIL pulse_3cyc k=%0d: out0=%b status0=%b, required %0d", k, irq_out[0], irq_status[0], k >= 5 && k <= 7);
      end
      if (k == 3) irq_in[0] = 1'b0;
    end
  endtask

  task automatic test_edge();
    irq_in[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc(1);
      checks++;
      if (irq_out[1] !== (k >= 6)) begin
        errors++;
        $display("FAIL edge_sticky k=%0d: out1=%b, required %0d", k, irq_out[1], k >= 6);
      end
      if (k == 4) irq_in[1] = 1'b0;
    end
    irq_clr[1] = 1'b1;
    cyc(1);
    irq_clr[1] = 1'b0;
    checks++;
    if (irq_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL edge_clear: out1=%b, required 0", irq_out[1]);
    end
    irq_in[0] = 1'b1; irq_in[2] = 1'b0;
    cyc(6);
    checks++;
    if (irq_out !== 4'b0101) begin
      errors++;
      $display("FAIL level_pair_assert: out=%b, required 0101", irq_out);
    end
    irq_clr = 4'b0101;
    cyc(1);
    irq_clr = '0;
    checks++;
    if (irq_out !== 4'b0101) begin
      errors++;
      $display("FAIL clr_ignored_level: out=%b, required 0101", irq_out);
    end
    irq_in[0] = 1'b0; irq_in[2] = 1'b1;
    cyc(8);
    checks++;
    if (irq_out !== '0 || wakeup !== 1'b0) begin
      errors++;
      $display("FAIL edge_idle: out=%b wakeup=%b, required 0", irq_out, wakeup);
    end
  endtask

  task automatic test_set_wins();
    irq_in[1] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      if (k >= 6) begin
        checks++;
        if (irq_out[1] !== 1'b1) begin
          errors++;
          $display("FAIL set_wins k=%0d: out1=%b, required 1", k, irq_out[1]);
        end
      end
      if (k == 4) irq_in[1] = 1'b0;
      irq_clr[1] = (k == 5);
    end
    irq_clr[1] = 1'b1;
    cyc(1);
    irq_clr[1] = 1'b0;
    checks++;
    if (irq_out[1] !== 1'b0 || wakeup !== 1'b0) begin
      errors++;
      $display("FAIL second_clear: out1=%b wakeup=%b, required 0", irq_out[1], wakeup);
    end
  endtask

  task automatic test_active_low_at_reset();
    rst = 1'b1; irq_in[2] = 1'b0; irq_in[3] = 1'b0;
    cyc(2);
    checks++;
    if (irq_out !== '0 || irq_status !== '0) begin
      errors++;
      $display("FAIL rst_dominates: out=%b status=%b, required 0", irq_out, irq_status);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (irq_status[2] !== (k >= 5) || irq_out[2] !== (k >= 5) || irq_out[3] !== (k >= 6)) begin
        errors++;
        $display("FAIL active_low_release k=%0d: status2=%b out2=%b out3=%b, required %0d %0d %0d",
                 k, irq_status[2], irq_out[2], irq_out[3], k >= 5, k >= 5, k >= 6);
      end
    end
    irq_in[2] = 1'b1; irq_in[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (irq_status[2] !== (k < 5) || irq_out[3] !== 1'b1) begin
        errors++;
        $display("FAIL active_low_deassert k=%0d: status2=%b out3=%b, required %0d 1", k, irq_status[2], irq_out[3], k < 5);
      end
    end
    irq_clr[3] = 1'b1;
    cyc(1);
    irq_clr[3] = 1'b0;
    checks++;
    if (irq_out !== '0) begin
      errors++;
      $display("FAIL active_low_clear: out=%b, required 0", irq_out);
    end
  endtask

  task automatic test_reset_mid_filter();
    irq_in[0] = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    checks++;
    if (irq_out !== '0 || irq_status !== '0 || wakeup !== 1'b0) begin
      errors++;
      $display("FAIL mid_filter_reset: out=%b status=%b wakeup=%b, required 0", irq_out, irq_status, wakeup);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (irq_out[0] !== (k >= 5)) begin
        errors++;
        $display("FAIL restart_after_reset k=%0d: out0=%b, required %0d", k, irq_out[0], k >= 5);
      end
    end
    irq_in[0] = 1'b0;
    cyc(8);
  endtask

  task automatic test_random();
    int thr;
    thr = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       thr = 1;
          1:       thr = 5;
          default: thr = 19;
        endcase
      end
      cyc(1);
      checks++;
      if (irq_out !== exp_out()) begin
        errors++;
        $display("FAIL rand_out c=%0d: out=%b, required %b", c, irq_out, exp_out());
      end
      checks++;
      if (irq_status !== m_filt) begin
        errors++;
        $display("FAIL rand_status c=%0d: status=%b, required %b", c, irq_status, m_filt);
      end
      checks++;
      if (wakeup !== (|exp_out())) begin
        errors++;
        $display("FAIL rand_wakeup c=%0d: wakeup=%b, required %b", c, wakeup, |exp_out());
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, thr) == 0) irq_in[i] = ~irq_in[i];
        irq_clr[i] = ($urandom_range(0, 5) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    irq_clr = '0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_glitch();
    test_edge();
    test_set_wins();
    test_active_low_at_reset();
    test_reset_mid_filter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
